// File: rtl/camerametnios_onchip_mem_arbiter.sv
// Two-port Avalon-MM arbiter in front of the 32K x 32 on-chip RAM.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module camerametnios_onchip_mem_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    output logic              mem_reset_req,
    input  logic [DATA_W-1:0] mem_readdata
);

    logic       req0, req1;
    logic       grant0, grant1;
    logic       lp, lp_nxt;
    logic       acc, acc_rd, acc_id;
    logic [1:0] pipe_v, pipe_id;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Last-grant pointer register (1 after reset so port 0 wins first)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lp <= 1'b1;
        else       lp <= lp_nxt;
    end

    // Pointer follows whichever port was accepted this cycle
    always_comb begin
        lp_nxt = lp;
        if (acc) lp_nxt = grant1;
    end

    // Grant decision; at most one port per cycle
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        grant0 = req0 & (~req1 | lp);
        grant1 = req1 & (~req0 | ~lp);
`else
        grant0 = req0;
        grant1 = req1 & ~req0;
`endif
        acc    = grant0 | grant1;
        acc_id = grant1;
        acc_rd = grant1 ? (m1_read & ~m1_write)
                        : (grant0 & m0_read & ~m0_write);
    end

    assign m0_waitrequest = req0 & ~grant0;
    assign m1_waitrequest = req1 & ~grant1;

    // Register the accepted command into the RAM; hold address/data when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
        end else if (acc) begin
            mem_chipselect <= 1'b1;
            mem_write      <= grant1 ? m1_write : m0_write;
            mem_address    <= grant1 ? m1_address : m0_address;
            mem_byteenable <= grant1 ? m1_byteenable : m0_byteenable;
            mem_writedata  <= grant1 ? m1_writedata : m0_writedata;
        end else begin
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
        end
    end

    // Two-stage response tag pipe matching the fixed read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_v  <= '0;
            pipe_id <= '0;
        end else begin
            pipe_v  <= {pipe_v[0], acc_rd};
            pipe_id <= {pipe_id[0], acc_id};
        end
    end

    assign m0_readdatavalid = pipe_v[1] & ~pipe_id[1];
    assign m1_readdatavalid = pipe_v[1] & pipe_id[1];
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign mem_clken        = 1'b1;
    assign mem_reset_req    = 1'b0;

endmodule
